// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer engine: FSM states, control-register
// field positions and interrupt status encodings.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FIN     = 3'd4
  } dma_state_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DIR     = 1;
  localparam int CTRL_ABORT   = 2;
  localparam int CTRL_LEN_LSB = 16;
  localparam int CTRL_LEN_MSB = 31;
  localparam int LEN_WIDTH    = CTRL_LEN_MSB - CTRL_LEN_LSB + 1;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = 16'd0;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = 16'd1;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_DONE  = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

endpackage

// File: rtl/dma_xfer_engine.sv
// Single-port DMA copy engine: moves LEN words between IO space and memory,
// one read followed by one write per word, then signals completion or abort.
module dma_xfer_engine
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] control,
  input  logic [DATA_WIDTH-1:0] io_address,
  input  logic [DATA_WIDTH-1:0] mem_address,
  output logic                  m_valid,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy,
  output logic                  intr_set,
  output logic [1:0]            intr_status
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

  dma_state_e            state_r;
  logic                  start_prev_r;
  logic                  abort_seen_r;
  logic [ADDR_WIDTH-1:0] src_r;
  logic [ADDR_WIDTH-1:0] dst_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [DATA_WIDTH-1:0] word_buf_r;
  logic                  m_valid_r;
  logic                  m_wr_en_r;
  logic [ADDR_WIDTH-1:0] m_addr_r;
  logic                  busy_r;
  logic                  intr_set_r;
  logic [1:0]            intr_status_r;

  logic                  start_edge_s;
  logic                  abort_s;
  logic                  dir_s;
  logic [LEN_WIDTH-1:0]  len_s;
  logic [ADDR_WIDTH-1:0] io_base_s;
  logic [ADDR_WIDTH-1:0] mem_base_s;

  assign start_edge_s = control[CTRL_START] & ~start_prev_r;
  assign abort_s      = control[CTRL_ABORT];
  assign dir_s        = control[CTRL_DIR];
  assign len_s        = control[CTRL_LEN_MSB:CTRL_LEN_LSB];
  assign io_base_s    = io_address[ADDR_WIDTH-1:0];
  assign mem_base_s   = mem_address[ADDR_WIDTH-1:0];

  assign m_valid     = m_valid_r;
  assign m_wr_en     = m_wr_en_r;
  assign m_addr      = m_addr_r;
  assign m_wdata     = word_buf_r;
  assign busy        = busy_r;
  assign intr_set    = intr_set_r;
  assign intr_status = intr_status_r;

  // Transfer FSM with its address/word counters, word buffer and registered master outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      start_prev_r  <= 1'b0;
      abort_seen_r  <= 1'b0;
      src_r         <= '0;
      dst_r         <= '0;
      remaining_r   <= '0;
      word_buf_r    <= '0;
      m_valid_r     <= 1'b0;
      m_wr_en_r     <= 1'b0;
      m_addr_r      <= '0;
      busy_r        <= 1'b0;
      intr_set_r    <= 1'b0;
      intr_status_r <= ST_NONE;
    end else begin
      start_prev_r <= control[CTRL_START];
      intr_set_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r       <= 1'b0;
          abort_seen_r <= 1'b0;
          // A start edge carrying abort is treated as a cancelled request.
          if (start_edge_s && !abort_s) begin
            busy_r      <= 1'b1;
            src_r       <= dir_s ? mem_base_s : io_base_s;
            dst_r       <= dir_s ? io_base_s : mem_base_s;
            remaining_r <= len_s;
            if (len_s == LEN_ZERO) begin
              state_r       <= FIN;
              intr_set_r    <= 1'b1;
              intr_status_r <= ST_DONE;
            end else begin
              state_r       <= RD_REQ;
              m_valid_r     <= 1'b1;
              m_wr_en_r     <= 1'b0;
              m_addr_r      <= dir_s ? mem_base_s : io_base_s;
              intr_status_r <= ST_NONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_REQ: begin
          if (m_ready) begin
            state_r   <= RD_WAIT;
            m_valid_r <= 1'b0;
          end else if (abort_s) begin
            state_r       <= FIN;
            m_valid_r     <= 1'b0;
            intr_set_r    <= 1'b1;
            intr_status_r <= ST_ABORT;
          end else begin
            state_r <= RD_REQ;
          end
        end
        RD_WAIT: begin
          // The outstanding read must drain before an abort can take effect.
          if (m_rvalid) begin
            if (abort_seen_r || abort_s) begin
              state_r       <= FIN;
              intr_set_r    <= 1'b1;
              intr_status_r <= ST_ABORT;
            end else begin
              state_r    <= WR_REQ;
              word_buf_r <= m_rdata;
              m_valid_r  <= 1'b1;
              m_wr_en_r  <= 1'b1;
              m_addr_r   <= dst_r;
            end
          end else begin
            abort_seen_r <= abort_seen_r | abort_s;
          end
        end
        WR_REQ: begin
          if (m_ready) begin
            src_r       <= src_r + STRIDE;
            dst_r       <= dst_r + STRIDE;
            remaining_r <= remaining_r - LEN_ONE;
            m_wr_en_r   <= 1'b0;
            if (remaining_r == LEN_ONE) begin
              state_r       <= FIN;
              m_valid_r     <= 1'b0;
              intr_set_r    <= 1'b1;
              intr_status_r <= ST_DONE;
            end else begin
              state_r   <= RD_REQ;
              m_valid_r <= 1'b1;
              m_addr_r  <= src_r + STRIDE;
            end
          end else if (abort_s) begin
            state_r       <= FIN;
            m_valid_r     <= 1'b0;
            m_wr_en_r     <= 1'b0;
            intr_set_r    <= 1'b1;
            intr_status_r <= ST_ABORT;
          end else begin
            state_r <= WR_REQ;
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          m_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Scoreboard bench for dma_xfer_engine: expected master requests and interrupt
// statuses are queued by the stimulus and popped by an independent monitor.
module tb_dma_xfer_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control;
  logic [31:0] io_address;
  logic [31:0] mem_address;
  logic        m_valid;
  logic        m_wr_en;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;
  logic        intr_set;
  logic [1:0]  intr_status;

  dma_xfer_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .control(control),
    .io_address(io_address), .mem_address(mem_address),
    .m_valid(m_valid), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .intr_set(intr_set), .intr_status(intr_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t       exp_q[$];
  logic [1:0] st_q[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int intr_count = 0;
  int valid_cycles = 0;
  int stall_cycles = 0;
  int stall_cnt = 0;
  int rd_lat = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  function automatic logic [31:0] ctrl(input logic [15:0] len, input logic dir, input logic abort);
    return {len, 13'd0, abort, dir, 1'b1};
  endfunction

  // Memory model: read data = address + 0x1111_0000, delivered rd_lat cycles after acceptance.
  initial begin
    logic [31:0] ra;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset && m_valid && m_ready && !m_wr_en) begin
        ra = m_addr;
        @(posedge clk);
        repeat (rd_lat) @(posedge clk);
        #1;
        m_rvalid = 1'b1;
        m_rdata  = ra + 32'h1111_0000;
        @(posedge clk);
        #1 m_rvalid = 1'b0;
      end
    end
  end

  // Ready driver: stalls the next stall_cnt write-request cycles.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0 && m_valid && m_wr_en) begin
        m_ready = 1'b0;
        stall_cnt--;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: scores accepted requests, stalled-request stability and interrupt pulses.
  initial begin
    logic pend;
    txn_t pend_t;
    txn_t e;
    logic intr_prev;
    pend = 1'b0;
    intr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        intr_prev = 1'b0;
      end else begin
        if (m_valid) valid_cycles++;
        if (pend)
          chk("hold_stable", {m_valid, m_wr_en, m_addr, m_wdata}, {1'b1, pend_t.wr, pend_t.addr, pend_t.data});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_req", $sformatf("wr=%0b addr=%0h", m_wr_en, m_addr));
          end else begin
            e = exp_q.pop_front();
            chk("req", {m_wr_en, m_addr, (m_wr_en ? m_wdata : 32'h0)}, {e.wr, e.addr, (e.wr ? e.data : 32'h0)});
          end
          if (m_wr_en) wr_count++;
          pend = 1'b0;
        end else if (m_valid) begin
          pend = 1'b1;
          pend_t = '{wr: m_wr_en, addr: m_addr, data: m_wdata};
          stall_cycles++;
        end else begin
          pend = 1'b0;
        end
        if (intr_set) begin
          intr_count++;
          if (st_q.size() == 0) fail("unexpected_intr", $sformatf("status=%0b", intr_status));
          else chk("intr_status", intr_status, st_q.pop_front());
          chk("intr_width", intr_prev, 1'b0);
        end
        intr_prev = intr_set;
      end
    end
  end

  task automatic start_and_wait(input logic [31:0] c, input logic [31:0] io, input logic [31:0] mem, output int cyc);
    @(negedge clk);
    #1;
    io_address  = io;
    mem_address = mem;
    control     = c;
    cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (intr_set) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) fail("intr_timeout", "no intr_set within 400 cycles");
    #1 control = 32'h0;
  endtask

  initial begin
    int cyc;
    int w0;
    int v0;
    int i0;
    int s0;
    int nrd;
    logic ok;
    reset = 1'b1;
    control = 32'h0;
    io_address = 32'h0;
    mem_address = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_wr_en", m_wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_intr_set", intr_set, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_intr_status", intr_status, 2'b00);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // LEN=4 io->mem, full throughput
    w0 = wr_count;
    for (int k = 0; k < 4; k++) begin
      exp_rd(32'h1000 + 32'(4 * k));
      exp_wr(32'h2000 + 32'(4 * k), 32'h1111_1000 + 32'(4 * k));
    end
    st_q.push_back(2'b01);
    start_and_wait(ctrl(16'd4, 1'b0, 1'b0), 32'h1000, 32'h2000, cyc);
    chk("t1_intr_cycle", cyc, 12);
    chk("t1_writes", wr_count - w0, 4);
    @(negedge clk);
    chk("t1_busy_after", {busy, intr_set}, 2'b00);

    // LEN=2 mem->io with first write stalled 5 cycles
    w0 = wr_count;
    s0 = stall_cycles;
    stall_cnt = 5;
    exp_rd(32'h4000); exp_wr(32'h3000, 32'h1111_4000);
    exp_rd(32'h4004); exp_wr(32'h3004, 32'h1111_4004);
    st_q.push_back(2'b01);
    start_and_wait(ctrl(16'd2, 1'b1, 1'b0), 32'h3000, 32'h4000, cyc);
    chk("t2_stall_cycles", stall_cycles - s0, 5);
    chk("t2_writes", wr_count - w0, 2);
    repeat (2) @(negedge clk);

    // LEN=0: no traffic, immediate completion
    v0 = valid_cycles;
    st_q.push_back(2'b01);
    start_and_wait(ctrl(16'd0, 1'b0, 1'b0), 32'h1000, 32'h2000, cyc);
    chk("t3_intr_cycle", cyc, 0);
    @(negedge clk);
    chk("t3_busy_after", {busy, intr_set}, 2'b00);
    chk("t3_no_valid", valid_cycles - v0, 0);
    repeat (2) @(negedge clk);

    // LEN=3 with source address wrapping past all-ones
    exp_rd(32'hFFFF_FFF8); exp_wr(32'h0000_0100, 32'h1110_FFF8);
    exp_rd(32'hFFFF_FFFC); exp_wr(32'h0000_0104, 32'h1110_FFFC);
    exp_rd(32'h0000_0000); exp_wr(32'h0000_0108, 32'h1111_0000);
    st_q.push_back(2'b01);
    start_and_wait(ctrl(16'd3, 1'b0, 1'b0), 32'hFFFF_FFF8, 32'h0000_0100, cyc);
    chk("t4_intr_cycle", cyc, 9);
    repeat (2) @(negedge clk);

    // Abort while idle and start+abort together: nothing launched
    v0 = valid_cycles;
    i0 = intr_count;
    @(negedge clk);
    #1 control = 32'h0000_0004;
    repeat (3) @(negedge clk);
    #1 control = 32'h0;
    @(negedge clk);
    #1 control = ctrl(16'd4, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_no_launch", {valid_cycles - v0, intr_count - i0}, 64'h0);
    #1 control = 32'h0;
    repeat (2) @(negedge clk);

    // LEN=8, abort during RD_WAIT of word 3
    rd_lat = 3;
    w0 = wr_count;
    exp_rd(32'h5000); exp_wr(32'h6000, 32'h1111_5000);
    exp_rd(32'h5004); exp_wr(32'h6004, 32'h1111_5004);
    exp_rd(32'h5008);
    st_q.push_back(2'b10);
    @(negedge clk);
    #1;
    io_address = 32'h5000;
    mem_address = 32'h6000;
    control = ctrl(16'd8, 1'b0, 1'b0);
    nrd = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_valid && m_ready && !m_wr_en) nrd++;
      if (nrd == 3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("t6_third_read", "third read not seen");
    @(negedge clk);
    chk("t6_in_rd_wait", {busy, m_valid}, 2'b10);
    #1 control = ctrl(16'd8, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (intr_set) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("t6_intr_timeout", "no intr_set after abort");
    #1 control = 32'h0;
    chk("t6_writes", wr_count - w0, 2);
    rd_lat = 0;
    repeat (3) @(negedge clk);

    // Reset during a stalled write, then a clean 1-word transfer
    stall_cnt = 100;
    i0 = intr_count;
    exp_rd(32'h7000);
    @(negedge clk);
    #1;
    io_address = 32'h7000;
    mem_address = 32'h8000;
    control = ctrl(16'd2, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid && m_wr_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("t7_wr_req", "write request not seen");
    #1 reset = 1'b1;
    #1;
    chk("t7_reset_outputs", {m_valid, busy, intr_set}, 3'b000);
    stall_cnt = 0;
    control = 32'h0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_no_intr", intr_count - i0, 0);
    exp_rd(32'h9000); exp_wr(32'hA000, 32'h1111_9000);
    st_q.push_back(2'b01);
    start_and_wait(ctrl(16'd1, 1'b0, 1'b0), 32'h9000, 32'hA000, cyc);
    chk("t7_intr_cycle", cyc, 3);
    repeat (3) @(negedge clk);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
